// File: rtl/c7bexu_lsu_ctl.sv
// Load/store control: LS1 alignment check, req/ack bus transaction, one LS3 pulse per op.
// Latency: vld edge to LS3 pulse is 3 cycles with immediate ack; bus stall bounded by TIMEOUT.
module c7bexu_lsu_ctl #(
  parameter int          TIMEOUT     = 16,
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_vld_e,
  input  logic [3:0]  lsu_op_e,
  input  logic [31:0] lsu_addr_e,
  input  logic [31:0] lsu_wdata_e,
  output logic        lsu_except_ale_ls1,
  output logic        lsu_except_buserr_ls3,
  output logic        lsu_except_ecc_ls3,
  output logic        lsu_data_valid_ls3,
  output logic        lsu_wr_fin_ls3,
  output logic [31:0] lsu_rdata_ls3,
  output logic [31:0] lsu_badv,
  output logic        lsu_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  input  logic        mem_ecc_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LS1  = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic          ecc_q;
  logic [31:0]   rdata_q;
  logic [31:0]   badv_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [3:0]    mem_wstrb_q;
  logic [31:0]   mem_wdata_q;

  logic [1:0]    size;
  logic          is_store;
  logic          is_uns;
  logic          ale_c;
  logic          timeout_c;
  logic [3:0]    wstrb_c;
  logic [31:0]   wdata_c;
  logic [31:0]   rshift_c;
  logic [31:0]   ext_c;

  assign size     = op_q[1:0];
  assign is_store = op_q[3];
  assign is_uns   = op_q[2];

  assign ale_c = (size == 2'd3) ||
                 (size == 2'd1 && addr_q[0]) ||
                 (size == 2'd2 && addr_q[1:0] != 2'b00);

  // The TIMEOUT-th REQ cycle is the one where the counter reads TIMEOUT-1.
  assign timeout_c = (state_q == S_REQ) && !mem_ack && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = wdata_q;
    case (size)
      2'd0: begin
        wstrb_c = 4'b0001 << addr_q[1:0];
        wdata_c = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        wstrb_c = 4'b0011 << addr_q[1:0];
        wdata_c = {2{wdata_q[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = wdata_q;
      end
    endcase
  end

  assign rshift_c = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ext_c = rshift_c;
    case (size)
      2'd0:    ext_c = {{24{~is_uns & rshift_c[7]}}, rshift_c[7:0]};
      2'd1:    ext_c = {{16{~is_uns & rshift_c[15]}}, rshift_c[15:0]};
      default: ext_c = rshift_c;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (lsu_vld_e) state_d = S_LS1;
      S_LS1:   state_d = ale_c ? S_IDLE : S_REQ;
      S_REQ:   if (mem_ack || timeout_c) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_d = (state_q == S_REQ) ? cnt_q + CW'(1) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= 4'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      ecc_q       <= 1'b0;
      rdata_q     <= RESET_RDATA;
      badv_q      <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wstrb_q <= 4'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && lsu_vld_e) begin
        op_q    <= lsu_op_e;
        addr_q  <= lsu_addr_e;
        wdata_q <= lsu_wdata_e;
      end
      if (state_q == S_LS1) begin
        if (ale_c) begin
          badv_q <= addr_q;
        end else begin
          mem_addr_q  <= {addr_q[31:2], 2'b00};
          mem_we_q    <= is_store;
          mem_wstrb_q <= wstrb_c;
          mem_wdata_q <= wdata_c;
        end
      end
      if (state_q == S_REQ) begin
        if (mem_ack) begin
          err_q <= mem_err;
          ecc_q <= mem_ecc_err;
          // Only a clean load completion replaces the visible load data.
          if (!is_store && !mem_err && !mem_ecc_err) rdata_q <= ext_c;
        end else if (timeout_c) begin
          err_q <= 1'b1;
          ecc_q <= 1'b0;
        end
      end
      if (state_q == S_RESP && (err_q || (!is_store && ecc_q))) badv_q <= addr_q;
    end
  end

  assign lsu_except_ale_ls1    = (state_q == S_LS1) && ale_c;
  assign lsu_except_buserr_ls3 = (state_q == S_RESP) && err_q;
  assign lsu_except_ecc_ls3    = (state_q == S_RESP) && !err_q && !is_store && ecc_q;
  assign lsu_wr_fin_ls3        = (state_q == S_RESP) && !err_q && is_store;
  assign lsu_data_valid_ls3    = (state_q == S_RESP) && !err_q && !is_store && !ecc_q;
  assign lsu_rdata_ls3         = rdata_q;
  assign lsu_badv              = badv_q;
  assign lsu_busy              = (state_q != S_IDLE);
  assign mem_req               = (state_q == S_REQ);
  assign mem_we                = mem_we_q;
  assign mem_addr              = mem_addr_q;
  assign mem_wstrb             = mem_wstrb_q;
  assign mem_wdata             = mem_wdata_q;

endmodule

// File: doc/c7bexu_lsu_ctl.md
Name: c7bexu_lsu_ctl

Overview:
Load/store unit control pipeline. It produces the LSU status signals consumed by c7bexu_ecl: lsu_except_ale_ls1, lsu_except_buserr_ls3, lsu_except_ecc_ls3, lsu_data_valid_ls3 and lsu_wr_fin_ls3. It accepts one memory op per lsu_vld_e, checks alignment in LS1, runs a req/ack bus transaction, and reports exactly one LS3 completion or exception pulse. It sits between the execute stage and the data-memory port.

Parameters:
TIMEOUT, 16, max cycles mem_req may wait for mem_ack before a bus error is forced (must be >= 2)
RESET_RDATA, 32'h0, reset/idle value of lsu_rdata_ls3

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
lsu_vld_e  input  1  op valid in E; sampled only in IDLE
lsu_op_e  input  4  [3]=store, [2]=unsigned load, [1:0]=size (0 byte, 1 half, 2 word, 3 reserved)
lsu_addr_e  input  32  byte address
lsu_wdata_e  input  32  store data, right-justified
lsu_except_ale_ls1  output  1  misaligned/reserved-size pulse
lsu_except_buserr_ls3  output  1  bus error/timeout pulse
lsu_except_ecc_ls3  output  1  load ECC error pulse
lsu_data_valid_ls3  output  1  load complete pulse
lsu_wr_fin_ls3  output  1  store complete pulse
lsu_rdata_ls3  output  32  extended load data, valid with lsu_data_valid_ls3
lsu_badv  output  32  address of last faulting op
lsu_busy  output  1  high in any state except IDLE
mem_req  output  1  bus request
mem_we  output  1  1=write
mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
mem_wstrb  output  4  byte lanes
mem_wdata  output  32  lane-shifted store data
mem_ack  input  1  transaction done
mem_rdata  input  32  read word, valid with mem_ack
mem_err  input  1  bus error, valid with mem_ack
mem_ecc_err  input  1  uncorrectable ECC, valid with mem_ack

Behaviour:
- Reset (synchronous): state=IDLE. All pulses, mem_req, mem_we, lsu_busy = 0. mem_wstrb=0, mem_addr=0, mem_wdata=0, lsu_badv=0, lsu_rdata_ls3=RESET_RDATA, timeout counter=0. Reset mid-transaction abandons the op with no LS3 pulse; a late mem_ack is ignored.
- FSM: IDLE -> LS1 -> {IDLE | REQ} ; REQ -> RESP -> IDLE.
- IDLE: on lsu_vld_e=1, register op, addr, wdata; next state LS1. lsu_vld_e in any other state is ignored.
- LS1 (1 cycle): ale = (size==3) | (size==1 & addr[0]) | (size==2 & addr[1:0]!=0).
  - ale=1: lsu_except_ale_ls1=1 for this cycle; lsu_badv<=addr; -> IDLE. No bus activity.
  - ale=0: -> REQ.
- REQ: mem_req=1; mem_addr, mem_we, mem_wstrb, mem_wdata held stable until the ack cycle.
  - wstrb: byte = 1<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111. Loads drive the same strobes.
  - wdata: replicate the byte/half across lanes.
  - The counter increments each REQ cycle.
  - mem_ack=1 in any REQ cycle, including the first: latch rdata/err/ecc; -> RESP; mem_req drops the next cycle.
  - No ack after TIMEOUT REQ cycles: force the err flag; -> RESP.
- RESP (1 cycle), exactly one pulse, in priority order:
  1. err or timeout -> buserr; lsu_badv<=addr.
  2. load & ecc -> ecc; lsu_badv<=addr.
  3. store -> wr_fin (store ecc ignored).
  4. load -> data_valid, with lsu_rdata_ls3 = lane extracted by addr[1:0], sign-extended unless unsigned.
  - lsu_rdata_ls3 holds until the next load completion.
  - -> IDLE; back-to-back ops accepted the following cycle.
- Minimum latency: lsu_vld_e at edge T -> LS3 pulse in cycle T+3 (immediate ack).

Test Plan:
- Word load, addr=0x100, ack on first REQ with rdata=0xDEADBEEF -> mem_addr=0x100, wstrb=4'hF, data_valid pulse 3 cycles after vld, lsu_rdata_ls3=0xDEADBEEF.
- Signed byte load, addr=0x103, rdata=0x80112233 -> lsu_rdata_ls3=0xFFFFFF80; same op unsigned -> 0x00000080.
- Half store, addr=0x202, wdata=0x1234, ack after 3 cycles -> mem_we=1, mem_addr=0x200, wstrb=4'b1100, mem_wdata=0x12341234, wr_fin single pulse.
- Word load, addr=0x101 -> ale pulse in LS1, lsu_badv=0x101, mem_req never asserts, busy drops the next cycle.
- Load with ack+mem_err+mem_ecc_err -> only buserr pulses. Load with no ack, TIMEOUT=16 -> buserr after 16 REQ cycles, lsu_badv=addr.
- reset asserted during REQ, then ack arrives -> no LS3 pulse, all outputs at reset values, next op completes normally.
